t10_uart_tx: RTL and testbench
==============================

T10_UART_TX -- requirements
Module: t10_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1042, clock cycles per UART bit (10 MHz / 9600 baud).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of queued bytes (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port nRst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tx_byte  input  8  byte to transmit.
REQ-006 SHALL have port tx_valid  input  1  tx_byte is offered this cycle.
REQ-007 SHALL have port tx_ready  output  1  FIFO can accept a byte (not full).
REQ-008 SHALL have port tx_serial  output  1  UART line, 8N1, idle high.
REQ-009 SHALL have port tx_busy  output  1  frame in progress or FIFO non-empty.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-011 SHALL accept a byte on each rising edge where tx_valid and tx_ready are both 1; it writes the byte to the FIFO tail.
REQ-012 SHALL ignore tx_valid while tx_ready is 0; the byte is dropped and no state changes.
REQ-013 SHALL drive tx_ready combinationally as (fifo_count != FIFO_DEPTH).
REQ-014 SHALL leave fifo_count unchanged on a cycle with a simultaneous push and pop; pointers wrap modulo FIFO_DEPTH.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, with registered tx_serial values 1, 0, current data bit, 1 respectively.
REQ-016 SHALL, in IDLE with the FIFO non-empty, pop the head byte into the shift register on the next edge and enter START; a byte pushed into an empty FIFO at edge N drives tx_serial low after edge N+1.
REQ-017 SHALL hold each of START, each DATA bit, and STOP for exactly CLKS_PER_BIT cycles, using a baud counter that counts 0..CLKS_PER_BIT-1 and resets on every bit boundary.
REQ-018 SHALL transmit data LSB first; a 3-bit index counts 0..7 and the FSM leaves DATA after bit 7.
REQ-019 SHALL, at the end of STOP with the FIFO non-empty, pop the head byte and enter START directly, with no idle cycle between frames.
REQ-020 SHALL, at the end of STOP with the FIFO empty, return to IDLE.
REQ-021 SHALL drive tx_busy to 1 whenever state != IDLE or fifo_count != 0.
REQ-022 SHALL start a frame only at the IDLE or STOP boundary; pushes during a frame only queue.

Reset
REQ-023 SHALL, while nRst=0, immediately force state=IDLE, tx_serial=1, fifo_count=0, tx_ready=1, tx_busy=0, and baud counter, bit index, pointers and shift register to 0.
REQ-024 SHALL, on reset mid-frame, abandon the frame and discard all queued bytes; the line goes high within the reset assertion and no partial frame resumes.

Structure
REQ-025 SHALL take the state enum (IDLE, START, DATA, STOP) from shared package t10_pkg, which also holds constant T10_UART_CLKS_PER_BIT=1042 for the receive and transmit sides.
REQ-026 SHALL place the FIFO in sub-module t10_tx_fifo (push/pop/full/empty/count), leaving the serializer FSM in t10_uart_tx.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-027 SHALL cover a single byte: push 0xA5 into an idle block. Required response: tx_serial low 1 cycle after the push edge, then bits 1,0,1,0,0,1,0,1 every 4 cycles, stop high 4 cycles, tx_busy falls, frame length 40 cycles.
REQ-028 SHALL cover back-to-back frames: push 0x01 then 0xFF on consecutive cycles. Required response: the second start bit immediately follows the first stop bit, with no high gap beyond 4 cycles.
REQ-029 SHALL cover a full FIFO: push 6 bytes 0x10..0x15 on consecutive cycles while valid is held. Required response: 0x10 popped, 0x11..0x14 queued, fifo_count=4, tx_ready=0, 0x15 dropped; the line carries exactly 5 frames.
REQ-030 SHALL cover a simultaneous push and pop: push at the STOP-end pop edge with fifo_count=2. Required response: fifo_count stays 2 and byte order is preserved.
REQ-031 SHALL cover reset mid-frame: assert nRst=0 during DATA bit 3 of 0x00 with 2 bytes queued. Required response: tx_serial=1 at once, fifo_count=0, and after release the line stays high with no frame.
REQ-032 SHALL cover a serial-line check: a UART receiver model sampling at bit centers decodes 0x00, 0x55, 0x80, 0xFF exactly.

Source files
------------

// File: rtl/t10_pkg.sv
// Shared UART definitions used by the t10 transmit and receive sides.
package t10_pkg;

   localparam int unsigned T10_UART_CLKS_PER_BIT = 1042;  // 10 MHz / 9600 baud

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

endpackage

// File: rtl/t10_tx_fifo.sv
// Byte FIFO feeding the UART serializer; pushes while full and pops while empty are ignored.
module t10_tx_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   nRst,
   input  logic                   push_i,
   input  logic [7:0]             wdata_i,
   input  logic                   pop_i,
   output logic [7:0]             rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [7:0]      mem_q [DEPTH];
   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CntW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/t10_uart_tx.sv
// 8N1 UART transmitter: queued bytes are serialized LSB first, frames sent back to back.
module t10_uart_tx
   import t10_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = T10_UART_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        nRst,
   input  logic [7:0]                  tx_byte,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        tx_serial,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

   uart_state_e      state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_serial_q, tx_serial_d;
   logic             pop, bit_end;
   logic             fifo_full, fifo_empty;
   logic [7:0]       fifo_head;

   t10_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .nRst    (nRst),
      .push_i  (tx_valid),
      .wdata_i (tx_byte),
      .pop_i   (pop),
      .rdata_o (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign tx_ready  = !fifo_full;
   assign tx_busy   = (state_q != IDLE) || !fifo_empty;
   assign tx_serial = tx_serial_q;
   assign bit_end   = (baud_q == BaudLast);

   // tx_serial_d always carries the line level of the state being entered.
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      tx_serial_d = tx_serial_q;
      pop         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop         = 1'b1;
               shift_d     = fifo_head;
               baud_d      = '0;
               state_d     = START;
               tx_serial_d = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               baud_d      = '0;
               bit_idx_d   = '0;
               state_d     = DATA;
               tx_serial_d = shift_q[0];
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d     = STOP;
                  tx_serial_d = 1'b1;
               end else begin
                  bit_idx_d   = bit_idx_q + 3'd1;
                  shift_d     = shift_q >> 1;
                  tx_serial_d = shift_q[1];
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  pop         = 1'b1;
                  shift_d     = fifo_head;
                  state_d     = START;
                  tx_serial_d = 1'b0;
               end else begin
                  state_d     = IDLE;
                  tx_serial_d = 1'b1;
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            tx_serial_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         tx_serial_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         tx_serial_q <= tx_serial_d;
      end
   end

endmodule

// File: tb/tb_t10_uart_tx.sv
// Scoreboard bench for t10_uart_tx: a line-level UART receiver pops expected bytes from a queue.
module tb_t10_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;
   localparam int MID   = CPB / 2;

   logic       clk      = 1'b0;
   logic       nRst     = 1'b0;
   logic [7:0] tx_byte  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_serial, tx_busy;
   logic [2:0] fifo_count;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   bit         rx_busy = 1'b0;
   int         rx_cnt  = 0;
   logic [7:0] rx_bits = 8'h00;

   // Occupancy model for one burst that begins on an idle line: the first byte leaves one edge
   // after its push, later ones every FRAME cycles while anything is queued.
   bit m_on  = 1'b0;
   int m_t0  = 0;
   int m_acc = 0;

   t10_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .nRst       (nRst),
      .tx_byte    (tx_byte),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_serial  (tx_serial),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int m_pops(input int e);
      int p;
      if (!m_on || e < m_t0 + 1) return 0;
      p = (e - m_t0 - 1) / FRAME + 1;
      return (p < m_acc) ? p : m_acc;
   endfunction

   // Called on a negedge; the push lands on the following rising edge.
   task automatic push(input logic [7:0] b);
      int e;
      int occ;
      bit acc;
      e = cyc + 1;
      if (!m_on) begin
         m_on  = 1'b1;
         m_t0  = e;
         m_acc = 0;
      end
      occ = m_acc - m_pops(e - 1);
      acc = (occ < DEPTH);
      check("tx_ready", 32'(tx_ready), 32'(acc));
      tx_byte  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      if (acc) begin
         m_acc++;
         exp_q.push_back(b);
      end
      check("fifo_count", 32'(fifo_count), 32'(m_acc - m_pops(e)));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((tx_busy !== 1'b0 || rx_busy) && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (n >= 600) begin
         total++;
         bad++;
         $display("FAIL wait_idle: still busy after %0d cycles", n);
      end
      repeat (2) @(negedge clk);
      m_on = 1'b0;
   endtask

   // Receiver model: samples each bit at its centre and compares against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (!nRst) begin
            rx_busy = 1'b0;
         end else if (!rx_busy) begin
            if (tx_serial === 1'b0) begin
               rx_busy = 1'b1;
               rx_cnt  = 0;
               starts.push_back(cyc);
            end
         end else begin
            rx_cnt++;
            if (rx_cnt == MID) begin
               check("start_bit", 32'(tx_serial), 32'd0);
            end else if (rx_cnt > MID && rx_cnt < MID + 9 * CPB && (rx_cnt - MID) % CPB == 0) begin
               rx_bits = {tx_serial, rx_bits[7:1]};
            end else if (rx_cnt == MID + 9 * CPB) begin
               check("stop_bit", 32'(tx_serial), 32'd1);
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL rx_frame: got %02h expected no frame", rx_bits);
               end else begin
                  check("rx_byte", 32'(rx_bits), 32'(exp_q.pop_front()));
               end
               rx_busy = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  t;
      bit  low_seen;
      bit  busy_seen;
      int  len;

      @(negedge clk);
      check("rst_serial", 32'(tx_serial), 32'd1);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd1);
      check("rst_busy", 32'(tx_busy), 32'd0);
      repeat (2) @(negedge clk);
      nRst = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte: start one cycle after the push edge, 40-cycle frame.
      starts.delete();
      push(8'hA5);
      t = m_t0;
      @(negedge clk);
      check("start_low", 32'(tx_serial), 32'd0);
      check("popped", 32'(fifo_count), 32'd0);
      while (cyc < t + FRAME) @(negedge clk);
      check("busy_last_stop", 32'(tx_busy), 32'd1);
      @(negedge clk);
      check("busy_fall", 32'(tx_busy), 32'd0);
      check("idle_high", 32'(tx_serial), 32'd1);
      check("single_frames", 32'(starts.size()), 32'd1);
      if (starts.size() > 0) check("start_latency", 32'(starts[0] - t), 32'd1);
      wait_idle();

      // Back-to-back frames.
      starts.delete();
      push(8'h01);
      push(8'hFF);
      wait_idle();
      check("b2b_frames", 32'(starts.size()), 32'd2);
      if (starts.size() == 2) check("b2b_gap", 32'(starts[1] - starts[0]), 32'(FRAME));

      // Full FIFO: sixth byte is dropped.
      starts.delete();
      for (int i = 0; i < 6; i++) push(8'(8'h10 + i));
      check("full_ready", 32'(tx_ready), 32'd0);
      check("full_count", 32'(fifo_count), 32'(DEPTH));
      wait_idle();
      check("full_frames", 32'(starts.size()), 32'd5);

      // Push on the STOP-end pop edge with two queued.
      starts.delete();
      for (int i = 0; i < 3; i++) push(8'($urandom));
      t = m_t0;
      while (cyc < t + FRAME) @(negedge clk);
      check("pre_pp_count", 32'(fifo_count), 32'd2);
      push(8'($urandom));
      check("pp_count", 32'(fifo_count), 32'd2);
      wait_idle();
      check("pp_frames", 32'(starts.size()), 32'd4);

      // Reset during data bit 3 of 0x00 with two bytes queued.
      starts.delete();
      push(8'h00);
      push(8'($urandom));
      push(8'($urandom));
      t = m_t0;
      while (cyc < t + 5 + 3 * CPB + 1) @(negedge clk);
      check("pre_rst_count", 32'(fifo_count), 32'd2);
      nRst = 1'b0;
      #1;
      check("mid_rst_serial", 32'(tx_serial), 32'd1);
      check("mid_rst_count", 32'(fifo_count), 32'd0);
      check("mid_rst_ready", 32'(tx_ready), 32'd1);
      check("mid_rst_busy", 32'(tx_busy), 32'd0);
      exp_q.delete();
      m_on = 1'b0;
      repeat (3) @(negedge clk);
      starts.delete();
      nRst = 1'b1;
      low_seen  = 1'b0;
      busy_seen = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (tx_serial !== 1'b1) low_seen = 1'b1;
         if (tx_busy !== 1'b0) busy_seen = 1'b1;
      end
      check("post_rst_line", 32'(low_seen), 32'd0);
      check("post_rst_busy", 32'(busy_seen), 32'd0);
      check("post_rst_frames", 32'(starts.size()), 32'd0);

      // Receiver decode of boundary patterns.
      starts.delete();
      push(8'h00);
      push(8'h55);
      push(8'h80);
      push(8'hFF);
      wait_idle();
      check("pattern_frames", 32'(starts.size()), 32'd4);

      // Random bursts with short gaps.
      for (int b = 0; b < 6; b++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         wait_idle();
      end

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
